// File: rtl/multicycle_control_pkg.sv
// ============================================================================
//  Module      : multicycle_control_pkg
//  Description : State encodings, opcode/funct constants and ALU op codes
//                shared by the multi-cycle control FSM and the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_LOAD_WB   = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage : multicycle_control_pkg

`default_nettype wire

// File: rtl/multicycle_control_alu_decoder.sv
// ============================================================================
//  Module      : multicycle_control_alu_decoder
//  Description : Combinational R-type funct -> ALU operation decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control_alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control,
    output logic       o_valid
);

    // Unknown funct falls back to ADD so the ALU never sees an undefined op.
    always_comb begin
        o_alu_control = ALU_ADD;
        o_valid       = 1'b1;
        case (i_funct)
            FUNCT_ADD: o_alu_control = ALU_ADD;
            FUNCT_SUB: o_alu_control = ALU_SUB;
            FUNCT_AND: o_alu_control = ALU_AND;
            FUNCT_OR:  o_alu_control = ALU_OR;
            FUNCT_SLT: o_alu_control = ALU_SLT;
            default:   o_valid       = 1'b0;
        endcase
    end

endmodule : multicycle_control_alu_decoder

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle control FSM sequencing fetch/decode/execute for
//                the load-operation datapath; sole source of alu_control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int STATE_W    = 4,
    parameter bit ENABLE_BEQ = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    state_t     r_state;
    state_t     w_next;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_control;
    logic       w_illegal_op;

    logic [2:0] w_dec_alu;
    logic       w_dec_valid;

    logic       w_is_lw;
    logic       w_is_sw;
    logic       w_is_rtype;
    logic       w_is_beq;

    // The zero flag qualifies pc_write_cond in the PC-load logic, not here.
    logic       w_unused_zero;
    assign w_unused_zero = zero;

    assign w_is_lw    = (opcode == OP_LW);
    assign w_is_sw    = (opcode == OP_SW);
    assign w_is_rtype = (opcode == OP_RTYPE);
    assign w_is_beq   = ENABLE_BEQ && (opcode == OP_BEQ);

    multicycle_control_alu_decoder u_alu_decoder (
        .i_funct       (funct),
        .o_alu_control (w_dec_alu),
        .o_valid       (w_dec_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next          = S_FETCH;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_reg_write     = 1'b0;
        w_reg_dst       = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_control   = ALU_AND;
        w_illegal_op    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read    = 1'b1;
                w_alu_src_b   = 2'b01;
                w_alu_control = ALU_ADD;
                w_ir_write    = mem_ready;
                w_pc_write    = mem_ready;
                w_next        = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                w_alu_src_b   = 2'b11;
                w_alu_control = ALU_ADD;
                if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM_ADDR;
                end else if (w_is_rtype) begin
                    w_next = S_EXECUTE;
                end else if (w_is_beq) begin
                    w_next = S_BRANCH;
                end else begin
                    w_illegal_op = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                w_alu_src_a   = 1'b1;
                w_alu_src_b   = 2'b10;
                w_alu_control = ALU_ADD;
                if (w_is_lw) begin
                    w_next = S_MEM_READ;
                end else if (w_is_sw) begin
                    w_next = S_MEM_WRITE;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM_READ: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                w_next     = mem_ready ? S_LOAD_WB : S_MEM_READ;
            end
            S_LOAD_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                w_next      = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_EXECUTE: begin
                w_alu_src_a   = 1'b1;
                w_alu_control = w_dec_alu;
                if (w_dec_valid) begin
                    w_next = S_R_WB;
                end else begin
                    w_illegal_op = 1'b1;
                    w_next       = S_FETCH;
                end
            end
            S_R_WB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_control   = ALU_SUB;
                w_pc_write_cond = 1'b1;
                w_next          = S_FETCH;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks every output combinationally so nothing escapes mid-abort.
    assign pc_write      = reset ? 1'b0  : w_pc_write;
    assign pc_write_cond = reset ? 1'b0  : w_pc_write_cond;
    assign iord          = reset ? 1'b0  : w_iord;
    assign mem_read      = reset ? 1'b0  : w_mem_read;
    assign mem_write     = reset ? 1'b0  : w_mem_write;
    assign ir_write      = reset ? 1'b0  : w_ir_write;
    assign reg_write     = reset ? 1'b0  : w_reg_write;
    assign reg_dst       = reset ? 1'b0  : w_reg_dst;
    assign mem_to_reg    = reset ? 1'b0  : w_mem_to_reg;
    assign alu_src_a     = reset ? 1'b0  : w_alu_src_a;
    assign alu_src_b     = reset ? 2'b00 : w_alu_src_b;
    assign alu_control   = reset ? 3'b000 : w_alu_control;
    assign illegal_op    = reset ? 1'b0  : w_illegal_op;
    assign state_dbg     = reset ? '0    : STATE_W'(r_state);

endmodule : multicycle_control

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected cycle sequences are
// built from the instruction rules and compared cycle by cycle.
`default_nettype none

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [3:0] state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [3:0]  st;
        logic        mr;
        logic [15:0] out;
    } step_t;

    step_t q[$];
    logic [2:0] alu_map [logic [5:0]];

    multicycle_control #(.STATE_W(4), .ENABLE_BEQ(1'b1)) dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .funct         (funct),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_control   (alu_control),
        .illegal_op    (illegal_op),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] observed();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
                alu_control, illegal_op};
    endfunction

    // Field order: pcw pcwc iord mrd mwr irw rw rd m2r asa asb alu ill
    function automatic logic [15:0] pk(input logic pcw, pcwc, io, mrd, mwr, irw,
                                       rw, rd, m2r, asa, input logic [1:0] asb,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, pcwc, io, mrd, mwr, irw, rw, rd, m2r, asa, asb, alu, ill};
    endfunction

    function automatic void push(input logic [5:0] op, fn, input logic [3:0] st,
                                 input logic mr, input logic [15:0] o);
        step_t s;
        s.op = op; s.fn = fn; s.st = st; s.mr = mr; s.out = o;
        q.push_back(s);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected per-cycle trace of one instruction, from the instruction rules.
    function automatic void gen(input logic [5:0] op, fn, input int fstall, mstall);
        logic known;
        logic [3:0] mem_st;
        known = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04);
        for (int i = 0; i < fstall; i++)
            push(op, fn, 4'd0, 1'b0, pk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b010,0));
        push(op, fn, 4'd0, 1'b1, pk(1,0,0,1,0,1,0,0,0,0,2'b01,3'b010,0));
        push(op, fn, 4'd1, rnd_bit(), pk(0,0,0,0,0,0,0,0,0,0,2'b11,3'b010,!known));
        if (!known) return;
        if (op == 6'h23 || op == 6'h2B) begin
            push(op, fn, 4'd2, rnd_bit(), pk(0,0,0,0,0,0,0,0,0,1,2'b10,3'b010,0));
            mem_st = (op == 6'h23) ? 4'd3 : 4'd5;
            for (int i = 0; i <= mstall; i++)
                push(op, fn, mem_st, (i == mstall),
                     pk(0,0,1,(op == 6'h23),(op == 6'h2B),0,0,0,0,0,2'b00,3'b000,0));
            if (op == 6'h23)
                push(op, fn, 4'd4, rnd_bit(), pk(0,0,0,0,0,0,1,0,1,0,2'b00,3'b000,0));
        end else if (op == 6'h00) begin
            if (alu_map.exists(fn)) begin
                push(op, fn, 4'd6, rnd_bit(), pk(0,0,0,0,0,0,0,0,0,1,2'b00,alu_map[fn],0));
                push(op, fn, 4'd7, rnd_bit(), pk(0,0,0,0,0,0,1,1,0,0,2'b00,3'b000,0));
            end else begin
                push(op, fn, 4'd6, rnd_bit(), pk(0,0,0,0,0,0,0,0,0,1,2'b00,3'b010,1));
            end
        end else begin
            push(op, fn, 4'd8, rnd_bit(), pk(0,1,0,0,0,0,0,0,0,1,2'b00,3'b110,0));
        end
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        step_t s;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            s = q.pop_front();
            @(negedge clk);
            opcode    = s.op;
            funct     = s.fn;
            mem_ready = s.mr;
            zero      = rnd_bit();
            #1;
            chk($sformatf("state op=%h fn=%h", s.op, s.fn), {12'd0, state_dbg}, {12'd0, s.st});
            chk($sformatf("outs st=%0d op=%h fn=%h", s.st, s.op, s.fn), observed(), s.out);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         pick;
        alu_map[6'h20] = 3'b010;
        alu_map[6'h22] = 3'b110;
        alu_map[6'h24] = 3'b000;
        alu_map[6'h25] = 3'b001;
        alu_map[6'h2A] = 3'b111;

        reset = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); #1;
            chk("reset_outs", observed(), 16'h0000);
            chk("reset_state", {12'd0, state_dbg}, 16'd0);
        end
        @(posedge clk); #1 reset = 1'b0;

        // Directed: lw, sub, slt, stalled lw, sw, beq, bad opcode, bad funct
        gen(6'h23, 6'h00, 0, 0); run(q.size());
        gen(6'h00, 6'h22, 0, 0); run(q.size());
        gen(6'h00, 6'h2A, 0, 0); run(q.size());
        gen(6'h23, 6'h00, 0, 2); run(q.size());
        gen(6'h2B, 6'h00, 0, 0); run(q.size());
        gen(6'h04, 6'h00, 0, 0); run(q.size());
        gen(6'h3F, 6'h00, 0, 0); run(q.size());
        gen(6'h00, 6'h07, 0, 0); run(q.size());

        // Reset while a load waits in MEM_READ must abandon it cleanly.
        gen(6'h23, 6'h00, 0, 3); run(4); q.delete();
        @(negedge clk);
        reset = 1'b1; mem_ready = 1'b1; #1;
        chk("midreset_outs", observed(), 16'h0000);
        chk("midreset_state", {12'd0, state_dbg}, 16'd0);
        @(posedge clk); #1 reset = 1'b0; mem_ready = 1'b0;
        @(negedge clk); #1;
        chk("postreset_state", {12'd0, state_dbg}, 16'd0);
        chk("postreset_outs", observed(), pk(0,0,0,1,0,0,0,0,0,0,2'b01,3'b010,0));

        // Randomized instruction mix with random memory stalls.
        for (int n = 0; n < 60; n++) begin
            pick = $urandom_range(0, 6);
            fn   = 6'($urandom);
            case (pick)
                0: op = 6'h23;
                1: op = 6'h2B;
                2: op = 6'h04;
                3: begin
                    op = 6'h00;
                    case ($urandom_range(0, 4))
                        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24;
                        3: fn = 6'h25; default: fn = 6'h2A;
                    endcase
                end
                4: op = 6'h00;
                default: begin
                    op = 6'($urandom);
                    while (op == 6'h00 || op == 6'h04 || op == 6'h23 || op == 6'h2B)
                        op = 6'($urandom);
                end
            endcase
            gen(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
            run(q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_multicycle_control

`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle control FSM that sequences the execution cycle for the load-operation datapath. It decodes opcode/funct from the instruction register and drives the ALU's 3-bit alu_control, mux selects and register/memory enables, one state per cycle. It sits directly upstream of the ALU and is the only source of alu_control. Memory accesses stall on a mem_ready handshake.

Parameters:
STATE_W, 4, width of state register / state_dbg port
ENABLE_BEQ, 1, 1 = branch path implemented; 0 = beq treated as illegal opcode

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
opcode  input  6  instr[31:26] from instruction register
funct  input  6  instr[5:0] from instruction register
zero  input  1  ALU zero flag
mem_ready  input  1  memory has completed current read/write this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if zero=1 (beq)
iord  output  1  memory address mux: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
reg_write  output  1  register file write
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  0 = ALUOut, 1 = MDR
alu_src_a  output  1  0 = PC, 1 = regA
alu_src_b  output  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
alu_control  output  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
illegal_op  output  1  one-cycle pulse on unsupported opcode/funct
state_dbg  output  STATE_W  current state encoding

Behaviour:
- Clock/reset: single clock clk; reset synchronous active-high. While reset=1 all outputs forced 0; state <= FETCH at the edge. First FETCH outputs appear the cycle after reset falls. Reset mid-instruction abandons it; no partial write after reset.
- Moore outputs decoded from state (plus mem_ready/zero where stated); no output registers.
- States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, LOAD_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=010; ir_write=pc_write=mem_ready. Stay until mem_ready=1, then DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_control=010 (branch target). Next: lw 0x23/sw 0x2B -> MEM_ADDR; R-type 0x00 -> EXECUTE; beq 0x04 -> BRANCH (if ENABLE_BEQ); else illegal_op=1, -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_control=010. lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1; hold until mem_ready, then LOAD_WB.
- LOAD_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WRITE: mem_write=1, iord=1; hold until mem_ready -> FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00; alu_control from funct: 0x20->010, 0x22->110, 0x24->000, 0x25->001, 0x2A->111. Unknown funct: illegal_op=1, alu_control=010, -> FETCH (no R_WB). Else -> R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_control=110, pc_write_cond=1 -> FETCH.
- Unlisted outputs are 0 in each state. Undefined state encodings -> FETCH next cycle, outputs 0.
- Latency (mem_ready high on first request): lw 5, sw 4, R-type 4, beq 3 cycles. Each mem_ready=0 cycle adds one.
- opcode/funct must be stable from DECODE to end of instruction (IR only loads in FETCH).

Decomposition:
- Shared package: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ), funct constants, ALU op codes (ALU_AND/OR/ADD/SUB/SLT) — the ALU and its bench reuse the ALU codes.
- One sub-module natural: alu_decoder (combinational funct -> alu_control + valid), instantiated in EXECUTE path.

Test Plan:
- Reset held 3 cycles, release, mem_ready=1, opcode=0x23 -> state_dbg 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5; alu_control=010 in cycles 1-3.
- R-type funct=0x22, mem_ready=1 -> EXECUTE alu_control=110, R_WB reg_dst=1, reg_write=1; 4 cycles total; funct=0x2A -> 111.
- lw with mem_ready=0 for 2 cycles in MEM_READ -> stays state 3, mem_read=1, iord=1 throughout; total 7 cycles; reg_write never early.
- sw 0x2B -> mem_write=1 only in MEM_WRITE, reg_write never 1; beq 0x04 with zero=1 -> BRANCH pc_write_cond=1, alu_control=110.
- opcode=0x3F -> illegal_op pulses in DECODE, back to FETCH; R-type funct=0x07 -> illegal_op in EXECUTE, no reg_write.
- reset asserted during MEM_READ -> next cycle all outputs 0, state FETCH; no reg_write issued.
